// File: rtl/register_128.sv
// 128-bit storage register for the compute module's register set.
// Loads D on the rising edge of Clock when Write is high; Clear zeroes it at once.
module register_128 (
    input  logic         Clock,
    input  logic         Clear,
    input  logic [127:0] D,
    input  logic         Write,
    output logic [127:0] Q
);

    logic [127:0] q_reg;

    // Clear wins over Write. A Clear held across an edge also blocks the load on that edge.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            q_reg <= '0;
        end else if (Write) begin
            q_reg <= D;
        end
    end

    assign Q = q_reg;

endmodule

// File: tb/tb_register_128.sv
// Self-checking bench for register_128: a reference model pushes expected contents
// to a queue at stimulus time, and each check pops one entry and compares it with Q.
module tb_register_128;

    logic         Clock;
    logic         Clear;
    logic [127:0] D;
    logic         Write;
    logic [127:0] Q;

    logic [127:0] exp_q[$];
    logic [127:0] mdl_q;
    int           n_checks;
    int           n_fail;

    register_128 dut (
        .Clock (Clock),
        .Clear (Clear),
        .D     (D),
        .Write (Write),
        .Q     (Q)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Apply one cycle of stimulus at the falling edge and push the expected result.
    task automatic drive_cycle(input logic [127:0] d, input logic w, input logic c);
        @(negedge Clock);
        D     = d;
        Write = w;
        Clear = c;
        if (c) mdl_q = '0;
        else if (w) mdl_q = d;
        exp_q.push_back(mdl_q);
        @(posedge Clock);
        #1;
    endtask

    task automatic check_q(input string name);
        logic [127:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, Q=%h", name, Q);
        end else begin
            e = exp_q.pop_front();
            if (Q !== e) begin
                n_fail++;
                $display("FAIL %s: Q=%h expected=%h", name, Q, e);
            end
        end
    endtask

    task automatic test_reset();
        D = '0; Write = 1'b0; Clear = 1'b0;
        // Contents are undefined here; this edge just proves Write=0 loads nothing.
        @(negedge Clock);
        @(posedge Clock);
        #2;
        Clear = 1'b1;
        mdl_q = '0;
        exp_q.push_back(mdl_q);
        #1;
        check_q("reset_async");
        drive_cycle({4{32'hFFFF_FFFF}}, 1'b1, 1'b1);
        check_q("reset_held_blocks_write");
        drive_cycle('0, 1'b0, 1'b0);
        check_q("reset_release_hold");
    endtask

    task automatic test_basic_load();
        drive_cycle(128'h0000_0000_0000_0000_0000_0006_0000_0003, 1'b1, 1'b0);
        check_q("basic_load");
        n_checks++;
        if (Q[127:64] !== 64'h0) begin
            n_fail++;
            $display("FAIL basic_load_upper: Q[127:64]=%h expected=0", Q[127:64]);
        end
    endtask

    task automatic test_overwrite();
        drive_cycle(128'h6, 1'b1, 1'b0);
        check_q("overwrite");
    endtask

    task automatic test_async_clear();
        #2;
        Clear = 1'b1;
        mdl_q = '0;
        exp_q.push_back(mdl_q);
        #1;
        check_q("async_clear_mid_cycle");
        drive_cycle({4{32'hFFFF_FFFF}}, 1'b1, 1'b1);
        check_q("clear_over_write");
    endtask

    task automatic test_full_width();
        drive_cycle({4{32'hFFFF_FFFF}}, 1'b1, 1'b0);
        check_q("full_width_ones");
        n_checks++;
        if (Q[127] !== 1'b1) begin
            n_fail++;
            $display("FAIL full_width_bit127: Q[127]=%b expected=1", Q[127]);
        end
        n_checks++;
        if (Q[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL full_width_bit0: Q[0]=%b expected=1", Q[0]);
        end
    endtask

    task automatic test_write_disable();
        drive_cycle({16{8'hA5}}, 1'b1, 1'b0);
        check_q("disable_load_a5");
        for (int i = 0; i < 3; i++) begin
            drive_cycle({16{8'h5A}}, 1'b0, 1'b0);
            check_q("disable_hold_a5");
        end
    endtask

    task automatic test_between_edges();
        logic [127:0] r;
        drive_cycle(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 1'b1, 1'b0);
        check_q("between_load");
        // D changes after the edge must not reach Q before the next edge.
        r = {$urandom, $urandom, $urandom, $urandom};
        D = r;
        exp_q.push_back(mdl_q);
        #2;
        check_q("between_no_comb_path");
    endtask

    task automatic test_back_to_back();
        logic [127:0] r;
        logic         w;
        for (int i = 0; i < 24; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            w = ($urandom_range(0, 3) != 0);
            drive_cycle(r, w, 1'b0);
            check_q("back_to_back");
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mdl_q    = '0;
        test_reset();
        test_basic_load();
        test_overwrite();
        test_async_clear();
        test_full_width();
        test_write_disable();
        test_between_edges();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
